// File: rtl/note_chart_recorder_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared types and helpers for the note chart recorder.
//   lane_code_t  : 2-bit per-lane note code stored in a chart line
//   LANE_*       : bit index of each fret in the 4-bit frets vector
//   rec_state_t  : recorder FSM states
//   encode_lane  : one lane's note code from (pressed, previously pressed)
//   encode_line  : full 8-bit chart line from current and previous frets
// -----------------------------------------------------------------------------
package note_pkg;

    typedef enum logic [1:0] {
        NOTE_NONE = 2'b00,
        NOTE_TAIL = 2'b01,
        NOTE_HEAD = 2'b10
    } lane_code_t;

    localparam int LANE_GREEN  = 3;
    localparam int LANE_YELLOW = 2;
    localparam int LANE_BLUE   = 1;
    localparam int LANE_ORANGE = 0;
    localparam int NUM_LANES   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        DONE   = 2'b10
    } rec_state_t;

    // A newly pressed fret starts a note (head); a fret still held extends it (tail).
    function automatic lane_code_t encode_lane(input logic pressed, input logic prev);
        lane_code_t code;
        if (pressed && !prev) begin
            code = NOTE_HEAD;
        end else if (pressed) begin
            code = NOTE_TAIL;
        end else begin
            code = NOTE_NONE;
        end
        return code;
    endfunction

    // Lane n occupies line bits [2n+1:2n], so green lands in [7:6] and orange in [1:0].
    function automatic logic [7:0] encode_line(input logic [3:0] frets, input logic [3:0] prev);
        logic [7:0] line;
        line = 8'h00;
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            line[2*lane +: 2] = encode_lane(frets[lane], prev[lane]);
        end
        return line;
    endfunction

endpackage

// File: rtl/note_line_ram.sv
// -----------------------------------------------------------------------------
// note_line_ram
// Single write / single read synchronous line RAM, read-first, WIDTH x DEPTH.
// Ports:
//   clk, reset          clock and synchronous active-high reset (read register only)
//   we, wr_addr, wr_data write port; wr_addr must be < DEPTH when we is high
//   rd_en, rd_addr      read request; rd_addr >= DEPTH reads as zero
//   rd_data             registered read data, holds while rd_en is low
// Memory contents are never cleared by reset.
// -----------------------------------------------------------------------------
module note_line_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2240,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Index width of the storage array; the counter-sized address carries one spare state.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_in_range_s;

    // Out-of-range read detection, so the truncated index never aliases a real line.
    always_comb begin
        rd_in_range_s = 1'b0;
        if (rd_addr < AW'(DEPTH)) begin
            rd_in_range_s = 1'b1;
        end else begin
            rd_in_range_s = 1'b0;
        end
    end

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // Read port: samples the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_in_range_s ? mem_r[rd_addr[IW-1:0]] : {WIDTH{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/note_chart_recorder.sv
// -----------------------------------------------------------------------------
// note_chart_recorder
// Records synchronised fret input as a note chart: one encoded 8-bit line per
// line_tick is written into an internal line RAM, readable at any time.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start, stop      pulses that begin / end a take
//   line_tick        one pulse per chart line period; samples frets
//   frets[3:0]       green, yellow, blue, orange (bit 3 .. bit 0)
//   rd_en, rd_addr   read request and line index
//   rd_data          line contents, valid one cycle after rd_en
//   rd_valid         registered rd_en
//   recording, done  FSM status
//   full             take ended because every line slot was written
//   lines_written    lines written in the current / last take
// -----------------------------------------------------------------------------
module note_chart_recorder
    import note_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2240,
    localparam int AW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             line_tick,
    input  logic [3:0]       frets,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             recording,
    output logic             done,
    output logic             full,
    output logic [AW-1:0]    lines_written
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_RECORD = RECORD;
    localparam logic [1:0] ST_DONE   = DONE;
    localparam logic [AW-1:0] LAST_COUNT = AW'(DEPTH);

    logic [1:0]       state_r;
    logic             recording_r;
    logic             done_r;
    logic             full_r;
    logic             rd_valid_r;
    logic [AW-1:0]    lines_written_r;
    logic [3:0]       prev_frets_r;

    logic             we_s;
    logic [AW-1:0]    next_count_s;
    logic [WIDTH-1:0] line_s;
    logic             hit_depth_s;

    // Line encoding, write strobe and the count after this tick's write.
    always_comb begin
        line_s       = encode_line(frets, prev_frets_r);
        next_count_s = lines_written_r + AW'(1);
        we_s         = 1'b0;
        hit_depth_s  = 1'b0;
        if ((state_r == ST_RECORD) && line_tick && !reset) begin
            we_s        = 1'b1;
            hit_depth_s = (next_count_s == LAST_COUNT);
        end else begin
            we_s        = 1'b0;
            hit_depth_s = 1'b0;
        end
    end

    // Recorder FSM, write counter, previous-fret history and read-valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            recording_r     <= 1'b0;
            done_r          <= 1'b0;
            full_r          <= 1'b0;
            rd_valid_r      <= 1'b0;
            lines_written_r <= {AW{1'b0}};
            prev_frets_r    <= 4'b0000;
        end else begin
            rd_valid_r <= rd_en;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // A new take starts from line 0 with no fret history,
                    // so anything already held records as a head.
                    if (start) begin
                        state_r         <= ST_RECORD;
                        recording_r     <= 1'b1;
                        done_r          <= 1'b0;
                        full_r          <= 1'b0;
                        lines_written_r <= {AW{1'b0}};
                        prev_frets_r    <= 4'b0000;
                    end
                end
                ST_RECORD: begin
                    if (we_s) begin
                        lines_written_r <= next_count_s;
                        prev_frets_r    <= frets;
                    end
                    // A stop coinciding with a tick still keeps that tick's line.
                    if (stop || hit_depth_s) begin
                        state_r     <= ST_DONE;
                        recording_r <= 1'b0;
                        done_r      <= 1'b1;
                        full_r      <= hit_depth_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    recording_r <= 1'b0;
                    done_r      <= 1'b0;
                    full_r      <= 1'b0;
                end
            endcase
        end
    end

    note_line_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (we_s),
        .wr_addr (lines_written_r),
        .wr_data (line_s),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_valid      = rd_valid_r;
    assign recording     = recording_r;
    assign done          = done_r;
    assign full          = full_r;
    assign lines_written = lines_written_r;

endmodule

// File: tb/tb_note_chart_recorder.sv
// -----------------------------------------------------------------------------
// tb_note_chart_recorder
// Table of directed vectors plus randomized traffic on a full-depth recorder,
// checked against a line-level reference model; a second, 4-line-deep
// recorder exercises the full condition.
// -----------------------------------------------------------------------------
module tb_note_chart_recorder;

    localparam int DEPTH  = 2240;
    localparam int AW     = 12;
    localparam int DEPTH4 = 4;
    localparam int AW4    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-depth DUT signals
    logic          reset, start, stop, line_tick, rd_en;
    logic [3:0]    frets;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_valid, recording, done, full;
    logic [AW-1:0] lines_written;

    // Small DUT signals
    logic           s_reset, s_start, s_stop, s_line_tick, s_rd_en;
    logic [3:0]     s_frets;
    logic [AW4-1:0] s_rd_addr;
    logic [7:0]     s_rd_data;
    logic           s_rd_valid, s_recording, s_done, s_full;
    logic [AW4-1:0] s_lines_written;

    note_chart_recorder #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .line_tick(line_tick),
        .frets(frets), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .recording(recording), .done(done), .full(full),
        .lines_written(lines_written)
    );

    note_chart_recorder #(.WIDTH(8), .DEPTH(DEPTH4)) dut4 (
        .clk(clk), .reset(s_reset), .start(s_start), .stop(s_stop), .line_tick(s_line_tick),
        .frets(s_frets), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .recording(s_recording), .done(s_done), .full(s_full),
        .lines_written(s_lines_written)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (full-depth DUT) ----------------
    // m_mode: 0 = idle, 1 = recording a take, 2 = take finished
    int       m_mode = 0;
    int       m_lines = 0;
    bit       m_full = 0;
    bit [3:0] m_prev = 0;
    bit [7:0] m_rd = 0;
    bit       m_rd_known = 1;
    bit       m_rv = 0;
    bit [7:0] m_mem [DEPTH];
    bit       m_known [DEPTH];

    function automatic int ref_line(input bit [3:0] f, input bit [3:0] p);
        int v = 0;
        for (int lane = 0; lane < 4; lane++) begin
            int code;
            if (!f[lane]) code = 0;
            else if (p[lane]) code = 1;
            else code = 2;
            v = v + code * (4 ** lane);
        end
        return v;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_lines = 0; m_full = 0; m_prev = 0;
            m_rd = 0; m_rd_known = 1; m_rv = 0;
            return;
        end
        m_rv = rd_en;
        if (rd_en) begin
            if (int'(rd_addr) >= DEPTH) begin
                m_rd = 8'h00; m_rd_known = 1;
            end else begin
                m_rd = m_mem[rd_addr]; m_rd_known = m_known[rd_addr];
            end
        end
        if (m_mode == 1) begin
            if (line_tick) begin
                m_mem[m_lines]   = 8'(ref_line(frets, m_prev));
                m_known[m_lines] = 1;
                m_lines++;
                m_prev = frets;
                if (m_lines == DEPTH) begin
                    m_mode = 2; m_full = 1;
                end
            end
            if (stop) m_mode = 2;
        end else if (start) begin
            m_mode = 1; m_lines = 0; m_full = 0; m_prev = 0;
        end
    endtask

    task automatic check_model();
        check("m_recording", 32'(recording), 32'(m_mode == 1));
        check("m_done", 32'(done), 32'(m_mode == 2));
        check("m_full", 32'(full), 32'(m_full));
        check("m_lines_written", 32'(lines_written), 32'(m_lines));
        check("m_rd_valid", 32'(rd_valid), 32'(m_rv));
        if (m_rd_known) check("m_rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    // One clock: model consumes the current inputs, then outputs are sampled 1ns after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst, st, sp, tk;
        logic [3:0] fr;
        logic re;
        logic [11:0] ra;
        logic e_rec, e_done, e_full;
        logic [11:0] e_lw;
        logic e_rv;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, st, sp, tk, input logic [3:0] fr, input logic re,
                       input logic [11:0] ra, input logic e_rec, e_done, e_full,
                       input logic [11:0] e_lw, input logic e_rv, input logic [7:0] e_rd);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.tk = tk; v.fr = fr; v.re = re; v.ra = ra;
        v.e_rec = e_rec; v.e_done = e_done; v.e_full = e_full; v.e_lw = e_lw;
        v.e_rv = e_rv; v.e_rd = e_rd;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; stop = 0; line_tick = 0; frets = 4'h0; rd_en = 0; rd_addr = '0;
    endtask

    initial begin
        idle_inputs();
        s_reset = 1; s_start = 0; s_stop = 0; s_line_tick = 0; s_frets = 4'h0;
        s_rd_en = 0; s_rd_addr = '0;
        #1;

        //   rst st sp tk fr    re addr      rec dn fl lw  rv rd
        add(1, 0, 0, 0, 4'h0, 0, 12'd0,    0, 0, 0, 0, 0, 8'h00); // reset state
        add(0, 1, 0, 0, 4'h0, 0, 12'd0,    1, 0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 1, 4'h8, 0, 12'd0,    1, 0, 0, 1, 0, 8'h00); // green head
        add(0, 0, 0, 1, 4'h8, 0, 12'd0,    1, 0, 0, 2, 0, 8'h00);
        add(0, 0, 0, 1, 4'h8, 0, 12'd0,    1, 0, 0, 3, 0, 8'h00);
        add(0, 0, 1, 0, 4'h0, 0, 12'd0,    0, 1, 0, 3, 0, 8'h00);
        add(0, 0, 0, 0, 4'h0, 1, 12'd0,    0, 1, 0, 3, 1, 8'h80);
        add(0, 0, 0, 0, 4'h0, 1, 12'd1,    0, 1, 0, 3, 1, 8'h40);
        add(0, 0, 0, 0, 4'h0, 1, 12'd2,    0, 1, 0, 3, 1, 8'h40);
        add(0, 0, 0, 0, 4'h0, 0, 12'd0,    0, 1, 0, 3, 0, 8'h40); // rd_data holds
        add(0, 0, 0, 1, 4'hF, 0, 12'd0,    0, 1, 0, 3, 0, 8'h40); // tick ignored in DONE
        add(0, 1, 0, 0, 4'hF, 0, 12'd0,    1, 0, 0, 0, 0, 8'h40); // new take
        add(0, 0, 0, 1, 4'hF, 0, 12'd0,    1, 0, 0, 1, 0, 8'h40); // AA
        add(0, 0, 0, 1, 4'h5, 0, 12'd0,    1, 0, 0, 2, 0, 8'h40); // 11
        add(0, 0, 0, 1, 4'hA, 0, 12'd0,    1, 0, 0, 3, 0, 8'h40); // 88
        add(0, 0, 1, 0, 4'h0, 1, 12'd0,    0, 1, 0, 3, 1, 8'hAA);
        add(0, 0, 0, 0, 4'h0, 1, 12'd1,    0, 1, 0, 3, 1, 8'h11);
        add(0, 0, 0, 0, 4'h0, 1, 12'd2,    0, 1, 0, 3, 1, 8'h88);
        add(0, 1, 0, 0, 4'h0, 0, 12'd0,    1, 0, 0, 0, 0, 8'h88);
        add(0, 0, 0, 1, 4'h1, 1, 12'd0,    1, 0, 0, 1, 1, 8'hAA); // read-first collision
        add(0, 0, 0, 1, 4'h0, 1, 12'd0,    1, 0, 0, 2, 1, 8'h02); // re-read sees new line
        add(0, 0, 1, 1, 4'h1, 0, 12'd0,    0, 1, 0, 3, 0, 8'h02); // stop + tick together
        add(0, 0, 0, 0, 4'h0, 1, 12'd2,    0, 1, 0, 3, 1, 8'h02);
        add(0, 0, 0, 0, 4'h0, 1, 12'd1,    0, 1, 0, 3, 1, 8'h00);
        add(0, 1, 0, 0, 4'h0, 0, 12'd0,    1, 0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 1, 4'h4, 0, 12'd0,    1, 0, 0, 1, 0, 8'h00); // 20
        add(0, 0, 0, 1, 4'h2, 0, 12'd0,    1, 0, 0, 2, 0, 8'h00); // 08
        add(1, 0, 0, 0, 4'h0, 0, 12'd0,    0, 0, 0, 0, 0, 8'h00); // reset mid-take
        add(0, 0, 0, 0, 4'h0, 1, 12'd0,    0, 0, 0, 0, 1, 8'h20);
        add(0, 0, 0, 0, 4'h0, 1, 12'd1,    0, 0, 0, 0, 1, 8'h08);
        add(0, 0, 1, 1, 4'hF, 0, 12'd0,    0, 0, 0, 0, 0, 8'h08); // ignored in IDLE
        add(0, 0, 0, 0, 4'h0, 1, 12'd4095, 0, 0, 0, 0, 1, 8'h00); // out of range
        add(0, 0, 0, 0, 4'h0, 1, 12'd2240, 0, 0, 0, 0, 1, 8'h00); // first invalid line

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp; line_tick = tbl[i].tk;
            frets = tbl[i].fr; rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            cycle();
            check($sformatf("t%0d_recording", i), 32'(recording), 32'(tbl[i].e_rec));
            check($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            check($sformatf("t%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            check($sformatf("t%0d_lines_written", i), 32'(lines_written), 32'(tbl[i].e_lw));
            check($sformatf("t%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rv));
            check($sformatf("t%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].e_rd));
            check_model();
        end
        idle_inputs();

        // ---------------- small DUT: take fills all 4 lines ----------------
        cycle();
        check("d4_reset_lw", 32'(s_lines_written), 32'd0);
        check("d4_reset_done", 32'(s_done), 32'd0);
        s_reset = 0; s_start = 1;
        cycle();
        s_start = 0;
        check("d4_start_rec", 32'(s_recording), 32'd1);
        for (int k = 0; k < 5; k++) begin
            s_line_tick = 1; s_frets = 4'b0001;
            cycle();
            check($sformatf("d4_tick%0d_lw", k), 32'(s_lines_written), 32'((k < 4) ? k + 1 : 4));
            check($sformatf("d4_tick%0d_done", k), 32'(s_done), 32'(k >= 3));
            check($sformatf("d4_tick%0d_full", k), 32'(s_full), 32'(k >= 3));
            check($sformatf("d4_tick%0d_rec", k), 32'(s_recording), 32'(k < 3));
        end
        s_line_tick = 0; s_frets = 4'b0000;
        s_rd_en = 1; s_rd_addr = 3'd4;
        cycle();
        check("d4_rd4_data", 32'(s_rd_data), 32'h00);
        check("d4_rd4_valid", 32'(s_rd_valid), 32'd1);
        s_rd_addr = 3'd0;
        cycle();
        check("d4_rd0_data", 32'(s_rd_data), 32'h02);
        s_rd_addr = 3'd3;
        cycle();
        check("d4_rd3_data", 32'(s_rd_data), 32'h01);
        s_rd_addr = 3'd7;
        cycle();
        check("d4_rd7_data", 32'(s_rd_data), 32'h00);
        s_rd_en = 0;

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            start     = ($urandom_range(0, 99) == 0);
            stop      = ($urandom_range(0, 79) == 0);
            line_tick = ($urandom_range(0, 2) == 0);
            frets     = 4'($urandom);
            rd_en     = 1'($urandom);
            if ($urandom_range(0, 9) == 0) rd_addr = 12'($urandom);
            else rd_addr = 12'($urandom_range(0, 15));
            cycle();
            check_model();
        end

        // ---------------- full-depth take ----------------
        idle_inputs();
        start = 1;
        cycle();
        check_model();
        start = 0;
        for (int c = 0; c < DEPTH + 3; c++) begin
            line_tick = 1;
            frets     = 4'($urandom);
            rd_en     = 1'($urandom);
            rd_addr   = 12'($urandom_range(0, DEPTH + 1));
            cycle();
            check_model();
        end
        idle_inputs();
        check("full_depth_full", 32'(full), 32'd1);
        check("full_depth_lw", 32'(lines_written), 32'(DEPTH));
        rd_en = 1; rd_addr = 12'(DEPTH - 1);
        cycle();
        check_model();
        rd_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
